// File: rtl/pe_row.sv
// 1-D output-stationary systolic MAC row with a backpressured serial drain.
// Define PE_ROW_SATURATE_EN to make each accumulate saturate instead of wrapping.
module pe_row #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned NUM_PE     = 4,
  parameter int unsigned SIGNED     = 0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic [DATA_WIDTH-1:0]          a_in,
  input  logic                           a_en,
  input  logic [NUM_PE*DATA_WIDTH-1:0]   b_in,
  output logic [DATA_WIDTH-1:0]          a_out,
  output logic                           en_out,
  output logic [NUM_PE*DATA_WIDTH-1:0]   b_out,
  input  logic                           drain_start,
  output logic [ACC_WIDTH-1:0]           res_data,
  output logic [$clog2(NUM_PE)-1:0]      res_idx,
  output logic                           res_valid,
  input  logic                           res_ready,
  output logic                           busy
);

  localparam int unsigned IdxW  = $clog2(NUM_PE);
  localparam int unsigned ProdW = 2 * DATA_WIDTH;

  typedef enum logic [0:0] {StAccum, StDrain} state_e;

  state_e                state_q, state_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [DATA_WIDTH-1:0] a_q [NUM_PE];
  logic [DATA_WIDTH-1:0] a_d [NUM_PE];
  logic [NUM_PE-1:0]     en_q, en_d;
  logic [DATA_WIDTH-1:0] b_q [NUM_PE];
  logic [DATA_WIDTH-1:0] b_d [NUM_PE];
  logic [ACC_WIDTH-1:0]  acc_q [NUM_PE];
  logic [ACC_WIDTH-1:0]  acc_d [NUM_PE];

  logic [DATA_WIDTH-1:0] pe_a [NUM_PE];
  logic [NUM_PE-1:0]     pe_en;
  logic [ACC_WIDTH-1:0]  addend [NUM_PE];

  function automatic logic [ACC_WIDTH-1:0] acc_add(input logic [ACC_WIDTH-1:0] acc,
                                                    input logic [ACC_WIDTH-1:0] inc);
`ifdef PE_ROW_SATURATE_EN
    logic [ACC_WIDTH:0] sum;
    if (SIGNED != 0) begin
      sum = {acc[ACC_WIDTH-1], acc} + {inc[ACC_WIDTH-1], inc};
      // Sign of the wide sum disagrees with the truncated sign only on overflow.
      if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
        return sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
      return sum[ACC_WIDTH-1:0];
    end else begin
      sum = {1'b0, acc} + {1'b0, inc};
      return sum[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
    end
`else
    return acc + inc;
`endif
  endfunction

  // Operand feeding each PE: PE0 sees the row inputs, later PEs the previous stage.
  always_comb begin
    pe_a[0]  = a_in;
    pe_en[0] = a_en;
    for (int i = 1; i < NUM_PE; i++) begin
      pe_a[i]  = a_q[i-1];
      pe_en[i] = en_q[i-1];
    end
  end

  always_comb begin
    logic [ProdW-1:0] op_a;
    logic [ProdW-1:0] op_b;
    logic [ProdW-1:0] prod;
    for (int i = 0; i < NUM_PE; i++) begin
      op_a = {{DATA_WIDTH{(SIGNED != 0) && pe_a[i][DATA_WIDTH-1]}}, pe_a[i]};
      op_b = {{DATA_WIDTH{(SIGNED != 0) && b_in[i*DATA_WIDTH+DATA_WIDTH-1]}},
              b_in[i*DATA_WIDTH +: DATA_WIDTH]};
      prod = op_a * op_b;
      addend[i] = {ACC_WIDTH{(SIGNED != 0) && prod[ProdW-1]}};
      addend[i][ProdW-1:0] = prod;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = en_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    unique case (state_q)
      StAccum: begin
        for (int i = 0; i < NUM_PE; i++) begin
          a_d[i]  = pe_a[i];
          en_d[i] = pe_en[i];
          if (pe_en[i]) begin
            b_d[i]   = b_in[i*DATA_WIDTH +: DATA_WIDTH];
            acc_d[i] = acc_add(acc_q[i], addend[i]);
          end
        end
        if (drain_start) begin
          state_d = StDrain;
          idx_d   = IdxW'(NUM_PE - 1);
          en_d    = '0;
        end
      end
      StDrain: begin
        if (res_ready) begin
          acc_d[0] = '0;
          for (int i = 1; i < NUM_PE; i++) acc_d[i] = acc_q[i-1];
          if (idx_q == '0) state_d = StAccum;
          else             idx_d   = idx_q - 1'b1;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StAccum;
      idx_q   <= '0;
      en_q    <= '0;
      for (int i = 0; i < NUM_PE; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        acc_q[i] <= '0;
      end
    end else if (clr) begin
      state_q <= StAccum;
      idx_q   <= '0;
      en_q    <= '0;
      for (int i = 0; i < NUM_PE; i++) begin
        a_q[i]   <= '0;
        b_q[i]   <= '0;
        acc_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      for (int i = 0; i < NUM_PE; i++) begin
        a_q[i]   <= a_d[i];
        b_q[i]   <= b_d[i];
        acc_q[i] <= acc_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_PE; g++) begin : gen_b_out
    assign b_out[g*DATA_WIDTH +: DATA_WIDTH] = b_q[g];
  end

  assign a_out     = a_q[NUM_PE-1];
  assign en_out    = en_q[NUM_PE-1];
  assign res_data  = acc_q[NUM_PE-1];
  assign res_idx   = idx_q;
  assign res_valid = (state_q == StDrain);
  assign busy      = (state_q == StDrain);

endmodule

// File: tb/tb_pe_row.sv
// Scoreboard bench for pe_row: three instances (unsigned/32, signed/32, unsigned/16).
module tb_pe_row;

  logic clk;
  logic rst_n;
  logic        clr_s     [3];
  logic [7:0]  a_in_s    [3];
  logic        a_en_s    [3];
  logic [31:0] b_in_s    [3];
  logic        drain_s   [3];
  logic        ready_s   [3];

  logic [7:0]  a_out_w   [3];
  logic        en_out_w  [3];
  logic [31:0] b_out_w   [3];
  logic [1:0]  idx_w     [3];
  logic        valid_w   [3];
  logic        busy_w    [3];
  logic [31:0] rd0, rd1;
  logic [15:0] rd2;
  logic [31:0] rdata     [3];

  assign rdata[0] = rd0;
  assign rdata[1] = rd1;
  assign rdata[2] = {16'h0, rd2};

  typedef struct {
    int          dut;
    logic [31:0] data;
    logic [1:0]  idx;
  } exp_t;

  exp_t exp_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  pe_row #(.DATA_WIDTH(8), .ACC_WIDTH(32), .NUM_PE(4), .SIGNED(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .clr(clr_s[0]), .a_in(a_in_s[0]), .a_en(a_en_s[0]),
    .b_in(b_in_s[0]), .a_out(a_out_w[0]), .en_out(en_out_w[0]), .b_out(b_out_w[0]),
    .drain_start(drain_s[0]), .res_data(rd0), .res_idx(idx_w[0]), .res_valid(valid_w[0]),
    .res_ready(ready_s[0]), .busy(busy_w[0])
  );

  pe_row #(.DATA_WIDTH(8), .ACC_WIDTH(32), .NUM_PE(4), .SIGNED(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr_s[1]), .a_in(a_in_s[1]), .a_en(a_en_s[1]),
    .b_in(b_in_s[1]), .a_out(a_out_w[1]), .en_out(en_out_w[1]), .b_out(b_out_w[1]),
    .drain_start(drain_s[1]), .res_data(rd1), .res_idx(idx_w[1]), .res_valid(valid_w[1]),
    .res_ready(ready_s[1]), .busy(busy_w[1])
  );

  pe_row #(.DATA_WIDTH(8), .ACC_WIDTH(16), .NUM_PE(4), .SIGNED(0)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr_s[2]), .a_in(a_in_s[2]), .a_en(a_en_s[2]),
    .b_in(b_in_s[2]), .a_out(a_out_w[2]), .en_out(en_out_w[2]), .b_out(b_out_w[2]),
    .drain_start(drain_s[2]), .res_data(rd2), .res_idx(idx_w[2]), .res_valid(valid_w[2]),
    .res_ready(ready_s[2]), .busy(busy_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input logic [31:0] data, input logic [1:0] idx);
    exp_t e;
    e.dut  = d;
    e.data = data;
    e.idx  = idx;
    exp_q.push_back(e);
  endtask

  task automatic issue(input int d, input logic [7:0] a, input logic [31:0] b);
    a_in_s[d] = a;
    b_in_s[d] = b;
    a_en_s[d] = 1'b1;
    tick();
    a_en_s[d] = 1'b0;
  endtask

  task automatic drain(input int d);
    drain_s[d] = 1'b1;
    tick();
    drain_s[d] = 1'b0;
  endtask

  task automatic wait_idle(input int d, input string name);
    int n = 0;
    while (busy_w[d] && n < 20) begin
      tick();
      n++;
    end
    chk({name, "_done"}, {31'b0, busy_w[d]}, 32'h0);
    chk({name, "_left"}, exp_q.size(), 32'h0);
  endtask

  // Monitor: every accepted word is matched against the scoreboard.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (valid_w[d] && ready_s[d]) begin
        if (exp_q.size() == 0) begin
          total_cnt++;
          $display("FAIL extra_word: dut%0d got %h idx %0d, required no word", d, rdata[d],
                   idx_w[d]);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("word_dut", d, e.dut);
          chk("word_data", rdata[d], e.data);
          chk("word_idx", {30'b0, idx_w[d]}, {30'b0, e.idx});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      clr_s[d] = 1'b0; a_in_s[d] = '0; a_en_s[d] = 1'b0; b_in_s[d] = '0;
      drain_s[d] = 1'b0; ready_s[d] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Reset in the middle of accumulation.
    issue(0, 8'd5, 32'h01010101);
    tick();
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) begin
      chk("rst_busy", {31'b0, busy_w[d]}, 32'h0);
      chk("rst_valid", {31'b0, valid_w[d]}, 32'h0);
      chk("rst_data", rdata[d], 32'h0);
      chk("rst_idx", {30'b0, idx_w[d]}, 32'h0);
      chk("rst_en_out", {31'b0, en_out_w[d]}, 32'h0);
      chk("rst_a_out", {24'b0, a_out_w[d]}, 32'h0);
      chk("rst_b_out", b_out_w[d], 32'h0);
    end
    for (int i = 3; i >= 0; i--) push(0, 32'h0, 2'(i));
    drain(0);
    wait_idle(0, "rst_drain");

    // One token a=3, b=2: four words of 6 back to back.
    tick();
    issue(0, 8'd3, 32'h02020202);
    repeat (3) tick();
    chk("pipe_en_out", {31'b0, en_out_w[0]}, 32'h1);
    chk("pipe_a_out", {24'b0, a_out_w[0]}, 32'h3);
    chk("pipe_b_out", b_out_w[0], 32'h02020202);
    tick();
    chk("pipe_en_out_low", {31'b0, en_out_w[0]}, 32'h0);
    for (int i = 3; i >= 0; i--) push(0, 32'd6, 2'(i));
    drain(0);
    chk("first_valid", {31'b0, valid_w[0]}, 32'h1);
    chk("first_idx", {30'b0, idx_w[0]}, 32'h3);
    chk("first_busy", {31'b0, busy_w[0]}, 32'h1);
    repeat (4) tick();
    chk("after4_busy", {31'b0, busy_w[0]}, 32'h0);
    chk("after4_valid", {31'b0, valid_w[0]}, 32'h0);
    chk("after4_left", exp_q.size(), 32'h0);

    // Same, with a two-cycle stall on the second word.
    tick();
    issue(0, 8'd3, 32'h02020202);
    repeat (4) tick();
    for (int i = 3; i >= 0; i--) push(0, 32'd6, 2'(i));
    drain(0);
    tick();
    ready_s[0] = 1'b0;
    chk("stall1_idx", {30'b0, idx_w[0]}, 32'h2);
    chk("stall1_data", rdata[0], 32'd6);
    tick();
    chk("stall2_idx", {30'b0, idx_w[0]}, 32'h2);
    chk("stall2_data", rdata[0], 32'd6);
    chk("stall2_valid", {31'b0, valid_w[0]}, 32'h1);
    ready_s[0] = 1'b1;
    wait_idle(0, "stall_drain");

    // Signed: a=-3 against lanes {2, -1, 1, 5}.
    tick();
    issue(1, 8'hFD, 32'h02FF0105);
    repeat (4) tick();
    push(1, 32'hFFFFFFFA, 2'd3);
    push(1, 32'h00000003, 2'd2);
    push(1, 32'hFFFFFFFD, 2'd1);
    push(1, 32'hFFFFFFF1, 2'd0);
    drain(1);
    wait_idle(1, "signed_drain");

    // 16-bit accumulators: 2 x 255*255 overflows.
    tick();
    issue(2, 8'hFF, 32'hFFFFFFFF);
    issue(2, 8'hFF, 32'hFFFFFFFF);
    repeat (4) tick();
`ifdef PE_ROW_SATURATE_EN
    for (int i = 3; i >= 0; i--) push(2, 32'h0000FFFF, 2'(i));
`else
    for (int i = 3; i >= 0; i--) push(2, 32'h0000FC02, 2'(i));
`endif
    drain(2);
    wait_idle(2, "acc16_drain");

    // clr in the middle of a drain.
    tick();
    issue(0, 8'd3, 32'h02020202);
    repeat (4) tick();
    push(0, 32'd6, 2'd3);
    drain(0);
    tick();
    ready_s[0] = 1'b0;
    chk("preclr_valid", {31'b0, valid_w[0]}, 32'h1);
    chk("preclr_idx", {30'b0, idx_w[0]}, 32'h2);
    clr_s[0] = 1'b1;
    tick();
    clr_s[0] = 1'b0;
    chk("clr_valid", {31'b0, valid_w[0]}, 32'h0);
    chk("clr_busy", {31'b0, busy_w[0]}, 32'h0);
    chk("clr_b_out", b_out_w[0], 32'h0);
    chk("clr_left", exp_q.size(), 32'h0);
    ready_s[0] = 1'b1;
    for (int i = 3; i >= 0; i--) push(0, 32'h0, 2'(i));
    drain(0);
    wait_idle(0, "clr_drain");

    tick();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
